// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port.
// Round-robin grants among N writeback requesters. The winner is registered into
// a one-cycle write command. A 32-entry busy scoreboard lets issue logic detect
// RAW and WAW hazards against writebacks that are still pending.
module regfile_wb_arbiter #(
  parameter int N    = 3,
  parameter int XLEN = 32
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [N-1:0]      req_valid,
  input  logic [5*N-1:0]    req_rd,
  input  logic [XLEN*N-1:0] req_wd,
  output logic [N-1:0]      req_ready,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [XLEN-1:0]   rf_wd,
  input  logic              sb_set,
  input  logic [4:0]        sb_set_rd,
  output logic              sb_set_ok,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic [5:0]        pending_cnt
);

  localparam int PW  = $clog2(N);
  localparam int PW1 = PW + 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic [31:0]     busy_q, busy_d;
  logic [5:0]      cnt_q, cnt_d;

  logic            found;
  logic [PW-1:0]   grantIdx;
  logic [PW:0]     idx;
  logic [4:0]      grantRd;
  logic [XLEN-1:0] grantWd;
  logic            setHit, clrHit;

  // Round-robin search starting at the pointer; the grant is suppressed while reset is held
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + PW1'(k);
      if (idx >= PW1'(N)) idx = idx - PW1'(N);
      if (!found && req_valid[idx[PW-1:0]]) begin
        found    = 1'b1;
        grantIdx = idx[PW-1:0];
      end
    end
    if (RST_X) found = 1'b0;
    req_ready = found ? (N'(1) << grantIdx) : '0;
  end

  // Select the winning requester's destination and data slices
  always_comb begin
    grantRd = '0;
    grantWd = '0;
    for (int i = 0; i < N; i++) begin
      if (PW'(i) == grantIdx) begin
        grantRd = req_rd[i*5 +: 5];
        grantWd = req_wd[i*XLEN +: XLEN];
      end
    end
  end

  // Next-state for the pointer and write command; a write to x0 completes the handshake but never writes
  always_comb begin
    ptr_d   = ptr_q;
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    if (found) begin
      ptr_d   = (grantIdx == PW'(N - 1)) ? '0 : grantIdx + PW'(1);
      rf_we_d = (grantRd != 5'd0);
      rf_rd_d = grantRd;
      rf_wd_d = grantWd;
    end
  end

  assign sb_set_ok = !busy_q[sb_set_rd] || (sb_set_rd == 5'd0);
  assign busy_rs1  = (rs1 != 5'd0) && busy_q[rs1];
  assign busy_rs2  = (rs2 != 5'd0) && busy_q[rs2];

  // Scoreboard update: a set of the same register that is being retired keeps the bit busy
  always_comb begin
    setHit = sb_set && sb_set_ok && (sb_set_rd != 5'd0);
    clrHit = rf_we_q && busy_q[rf_rd_q] && !(sb_set && (sb_set_rd == rf_rd_q));
    busy_d = busy_q;
    if (clrHit) busy_d[rf_rd_q] = 1'b0;
    if (setHit) busy_d[sb_set_rd] = 1'b1;
    cnt_d = cnt_q;
    case ({setHit, clrHit})
      2'b10:   cnt_d = cnt_q + 6'd1;
      2'b01:   cnt_d = cnt_q - 6'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      ptr_q   <= '0;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_rd       = rf_rd_q;
  assign rf_wd       = rf_wd_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (N=3, XLEN=32).
// Inputs change 1 time unit after the rising edge. Outputs are checked after a
// further settle delay.
module tb_regfile_wb_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 32;

  logic              CLK;
  logic              RST_X;
  logic [N-1:0]      req_valid;
  logic [5*N-1:0]    req_rd;
  logic [XLEN*N-1:0] req_wd;
  logic [N-1:0]      req_ready;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [XLEN-1:0]   rf_wd;
  logic              sb_set;
  logic [4:0]        sb_set_rd;
  logic              sb_set_ok;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              busy_rs1;
  logic              busy_rs2;
  logic [5:0]        pending_cnt;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.N(N), .XLEN(XLEN)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd), .req_ready(req_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd), .sb_set_ok(sb_set_ok),
    .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .pending_cnt(pending_cnt)
  );

  // Free-running clock, period 10
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [14:0] rd, input logic [95:0] wd);
    req_valid = v;
    req_rd    = rd;
    req_wd    = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Directed sequence
  initial begin
    logic [95:0] wdRR;
    logic [14:0] rdRR;
    wdRR = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    rdRR = {5'd7, 5'd6, 5'd5};
    RST_X = 1'b1; sb_set = 1'b0; sb_set_rd = '0; rs1 = '0; rs2 = '0;
    applyStimulus(3'b111, rdRR, wdRR);
    checkOutput("reset_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_we", 64'(rf_we), 64'h0);
    checkOutput("reset_cnt", 64'(pending_cnt), 64'h0);
    tick();
    tick();
    RST_X = 1'b0;
    #1;
    checkOutput("first_grant", 64'(req_ready), 64'h1);

    // Round robin with all three requesting
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("rr_ready%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
      tick();
      checkOutput($sformatf("rr_we%0d", c), 64'(rf_we), 64'h1);
      checkOutput($sformatf("rr_rd%0d", c), 64'(rf_rd), 64'(5 + (c % 3)));
      checkOutput($sformatf("rr_wd%0d", c), 64'(rf_wd), 64'(32'hA000_0000 + (c % 3)));
    end
    applyStimulus(3'b000, rdRR, wdRR);
    checkOutput("idle_ready", 64'(req_ready), 64'h0);
    tick();
    checkOutput("idle_we", 64'(rf_we), 64'h0);
    checkOutput("rr_cnt", 64'(pending_cnt), 64'h0);

    // Single requester (index 2)
    applyStimulus(3'b100, {5'd9, 5'd0, 5'd0}, {32'hDEAD_BEEF, 64'h0});
    checkOutput("single_ready", 64'(req_ready), 64'h4);
    tick();
    applyStimulus(3'b000, '0, '0);
    checkOutput("single_we", 64'(rf_we), 64'h1);
    checkOutput("single_rd", 64'(rf_rd), 64'd9);
    checkOutput("single_wd", 64'(rf_wd), 64'hDEAD_BEEF);

    // rd=0 transfer: handshake only
    applyStimulus(3'b010, '0, {32'h0, 32'h1234_5678, 32'h0});
    checkOutput("rd0_ready", 64'(req_ready), 64'h2);
    tick();
    applyStimulus(3'b000, '0, '0);
    checkOutput("rd0_we", 64'(rf_we), 64'h0);
    checkOutput("rd0_cnt", 64'(pending_cnt), 64'h0);
    applyStimulus(3'b111, rdRR, wdRR);
    checkOutput("rd0_ptr", 64'(req_ready), 64'h4);
    applyStimulus(3'b000, '0, '0);
    tick();

    // Scoreboard RAW/WAW on x10
    sb_set = 1'b1; sb_set_rd = 5'd10;
    #1;
    checkOutput("sb_ok_free", 64'(sb_set_ok), 64'h1);
    tick();
    sb_set = 1'b0; rs1 = 5'd10; rs2 = 5'd0;
    #1;
    checkOutput("sb_busy10", 64'(busy_rs1), 64'h1);
    checkOutput("sb_busy_x0", 64'(busy_rs2), 64'h0);
    checkOutput("sb_ok_waw", 64'(sb_set_ok), 64'h0);
    checkOutput("sb_cnt1", 64'(pending_cnt), 64'd1);
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd10}, {64'h0, 32'h0000_00AA});
    checkOutput("alu_ready", 64'(req_ready), 64'h1);
    tick();
    applyStimulus(3'b000, '0, '0);
    checkOutput("alu_we", 64'(rf_we), 64'h1);
    checkOutput("alu_rd", 64'(rf_rd), 64'd10);
    checkOutput("alu_busy_during", 64'(busy_rs1), 64'h1);
    checkOutput("alu_cnt_during", 64'(pending_cnt), 64'd1);
    tick();
    checkOutput("alu_busy_after", 64'(busy_rs1), 64'h0);
    checkOutput("alu_cnt_after", 64'(pending_cnt), 64'd0);

    // Set/clear collision on x12
    sb_set = 1'b1; sb_set_rd = 5'd12;
    tick();
    sb_set = 1'b0; rs1 = 5'd12;
    applyStimulus(3'b010, {5'd0, 5'd12, 5'd0}, {32'h0, 32'h0000_0C0C, 32'h0});
    checkOutput("col_ready", 64'(req_ready), 64'h2);
    checkOutput("col_cnt_pre", 64'(pending_cnt), 64'd1);
    tick();
    applyStimulus(3'b000, '0, '0);
    sb_set = 1'b1; sb_set_rd = 5'd12;
    #1;
    checkOutput("col_we", 64'(rf_we), 64'h1);
    checkOutput("col_ok", 64'(sb_set_ok), 64'h0);
    tick();
    sb_set = 1'b0;
    #1;
    checkOutput("col_busy", 64'(busy_rs1), 64'h1);
    checkOutput("col_cnt", 64'(pending_cnt), 64'd1);

    // Mid-stream reset
    applyStimulus(3'b111, rdRR, wdRR);
    checkOutput("pre_rst_ready", 64'(req_ready), 64'h4);
    tick();
    checkOutput("pre_rst_we", 64'(rf_we), 64'h1);
    RST_X = 1'b1;
    #1;
    checkOutput("rst_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_we", 64'(rf_we), 64'h0);
    checkOutput("rst_cnt", 64'(pending_cnt), 64'h0);
    checkOutput("rst_busy", 64'(busy_rs1), 64'h0);
    tick();
    RST_X = 1'b0;
    #1;
    checkOutput("post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    checkOutput("post_rst_we", 64'(rf_we), 64'h1);
    checkOutput("post_rst_rd", 64'(rf_rd), 64'd5);
    applyStimulus(3'b000, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port among N writeback requesters (ALU, LSU, CSR/debug) using round-robin arbitration with valid/ready handshakes.
- Drives a registered write command (we/rd/wd) into the register file.
- Holds a 32-entry busy scoreboard so issue logic can stall on RAW and WAW hazards against pending writebacks.
- Sits between the execute/memory stages and the register file.

Parameters:
- N, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_X  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-requester write request.
- req_rd  in  5*N  destination register; requester i uses bits [5i+4:5i].
- req_wd  in  XLEN*N  write data; requester i uses slice i.
- req_ready  out  N  one-hot grant; combinational.
- rf_we  out  1  register-file write enable; registered.
- rf_rd  out  5  register-file destination; registered.
- rf_wd  out  XLEN  register-file write data; registered.
- sb_set  in  1  issue stage marks a destination as pending.
- sb_set_rd  in  5  register to mark.
- sb_set_ok  out  1  combinational; 0 if sb_set_rd is already busy (WAW stall).
- rs1, rs2  in  5 each  source registers to query.
- busy_rs1, busy_rs2  out  1 each  combinational; 1 if the queried register has a pending write.
- pending_cnt  out  6  number of busy bits set; registered.

Behaviour:
- Reset (RST_X=1, asynchronous): rf_we=0, rf_rd=0, rf_wd=0, scoreboard all 0, pending_cnt=0, rr pointer=0.
- Reset asserted mid-operation discards in-flight grants. req_ready is forced to 0 while RST_X=1.
- Arbitration: search req_valid starting at index ptr, wrapping modulo N. The first valid index g gets req_ready[g]=1; all others get 0. No valid request gives req_ready=0.
- A transfer occurs when req_valid[g]=1 and req_ready[g]=1. On that edge ptr<=(g+1) mod N. Otherwise ptr holds.
- Requesters must hold valid/rd/wd stable until ready. Dropping valid without a grant is legal.
- Latency: the grant cycle registers {rf_we, rf_rd, rf_wd}, so they are visible exactly 1 cycle after the handshake. The register file commits on the following negedge.
- rf_we is high only for the single cycle following each transfer; back-to-back transfers give consecutive rf_we pulses.
- rd=0 transfer: the handshake completes (ready given, ptr advances), but rf_we stays 0 and the scoreboard is untouched.
- Scoreboard set: if sb_set=1 and sb_set_rd!=0 and the bit is clear, set busy[sb_set_rd] on posedge. sb_set_ok = !(busy[sb_set_rd]) | (sb_set_rd==0). sb_set while sb_set_ok=0 is ignored.
- Scoreboard clear: on posedge where rf_we=1, clear busy[rf_rd]. The bit is therefore still busy during the cycle the write is presented and reads as clear starting the next cycle.
- Simultaneous set and clear of the same rd: set wins, so the bit stays 1. sb_set_ok evaluates the pre-clear state and is therefore 0 in that cycle.
- busy_rsX: busy[rsX] from the current register, with no bypass. Register x0 always reads 0.
- A writeback to a non-busy rd (e.g. debug) is allowed and performs the write; clearing a clear bit has no effect.
- pending_cnt tracks the popcount of the scoreboard, updated on the same edge as the bits (+1, -1, or 0 net).

Test Plan:
- Reset: drive RST_X=1 mid-stream with req_valid=3'b111 -> req_ready=0, rf_we=0 immediately. After release: pending_cnt=0 and the first grant goes to index 0.
- Round-robin fairness: hold req_valid=3'b111 (rd=5,6,7) for 6 cycles -> grants 0,1,2,0,1,2; rf_we high for 6 cycles starting 1 cycle later; rf_rd sequence 5,6,7,5,6,7.
- Single requester: only req_valid[2]=1 with rd=9, wd=0xDEADBEEF -> req_ready=3'b100 the same cycle; next cycle rf_we=1, rf_rd=9, rf_wd=0xDEADBEEF.
- rd=0 write: req_valid[1]=1, rd=0 -> req_ready[1]=1, ptr advances to 2, rf_we stays 0, pending_cnt unchanged.
- Scoreboard RAW/WAW: sb_set rd=10 -> next cycle busy_rs1(rs1=10)=1, sb_set_ok(rd=10)=0, pending_cnt=1. ALU writes rd=10 -> busy_rs1 stays 1 during the rf_we cycle and reads 0 the cycle after; pending_cnt=0.
- Set/clear collision: rd=12 busy and rf_we=1 with rf_rd=12 while sb_set rd=12 -> busy[12] stays 1, pending_cnt unchanged at 1, sb_set_ok=0 that cycle.
